// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART stages (TX now, RX later).
// State encodings, frame width and the default baud divisor live here.
package fifo_uart_pkg;

    localparam int UART_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_READ  = S_READ,
        ST_LOAD  = S_LOAD,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP
    } uart_state_t;

    // Width of a counter that must hold 0..cpb-1 (at least one bit).
    function automatic int baud_cnt_w(input int cpb);
        return (cpb > 2) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while clr is low and
// raises tick on the last cycle of every bit period.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W    = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;

    // tick is registered one cycle early so it lines up with cnt == CNT_LAST.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
            tick_reg <= (cnt_reg == CNT_PRE);
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from the FIFO read port and
// shifts it out as an 8N1 UART frame, LSB first.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = UART_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_BITS - 1);

    uart_state_t       state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic              tx_reg, tx_next;
    logic              fifo_rd_reg;
    logic              busy_reg;
    logic              baud_clr;
    logic              tick;

    // The baud counter only runs while a frame is on the line.
    assign baud_clr = !(state_reg inside {ST_START, ST_DATA, ST_STOP});

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = 1'b1;
        case (state_reg)
            ST_IDLE:  if (en && !fifo_empty) state_next = ST_READ;
            ST_READ:  state_next = ST_LOAD;
            ST_LOAD: begin
                shift_next = fifo_data;
                state_next = ST_START;
            end
            ST_START: if (tick) begin
                state_next   = ST_DATA;
                bit_idx_next = '0;
            end
            ST_DATA: if (tick) begin
                if (bit_idx_reg == LAST_BIT) state_next   = ST_STOP;
                else                         bit_idx_next = bit_idx_reg + 3'd1;
            end
            ST_STOP:  if (tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Line level is decoded from the next state so tx itself is a flop.
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[bit_idx_next];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
            fifo_rd_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
            fifo_rd_reg <= (state_next == ST_READ);
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    assign tx      = tx_reg;
    assign fifo_rd = fifo_rd_reg;
    assign busy    = busy_reg;
    assign tx_done = (state_reg == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: an 8-deep FIFO model feeds the DUT and a
// frame-timeline model predicts tx/fifo_rd/busy/tx_done on every cycle.
module tb_fifo_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       dut_empty;
    logic [7:0] dut_data;
    logic       fifo_rd, tx, busy, tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_empty(dut_empty), .fifo_data(dut_data),
        .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // FIFO model: registered data_out valid the cycle after rd.
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       f_empty = 1'b1;
    logic [7:0] f_data  = 8'h00;
    logic       wr      = 1'b0;
    logic [7:0] wdata   = 8'h00;
    logic       noise_on = 1'b0;
    logic       noise_empty = 1'b0;
    logic [7:0] noise_data = 8'h00;
    logic       test6 = 1'b0;

    assign dut_empty = noise_on ? noise_empty : f_empty;
    assign dut_data  = noise_on ? noise_data  : f_data;

    // Frame model: m_t is the position of the current cycle within a frame
    // (1 = read strobe, 2 = capture, 3.. = line bits), -1 when idle.
    int         m_t = -1;
    logic [7:0] m_byte = 8'h00;
    logic       started = 1'b0;
    logic       rst_edge = 1'b0;

    always @(posedge clk) begin
        cyc++;
        started  = 1'b1;
        rst_edge = rst;
        if (rst) m_t = -1;
        else if (m_t < 0) begin
            if (en && !dut_empty) begin
                m_t    = 1;
                m_byte = exp_q.pop_front();
            end
        end else begin
            m_t++;
            if (m_t == FRAME + 3) m_t = -1;
        end
        if (fifo_rd && fq.size() > 0) f_data <= fq.pop_front();
        if (wr && fq.size() < 8) begin
            fq.push_back(wdata);
            exp_q.push_back(wdata);
        end
        f_empty <= (fq.size() == 0);
    end

    int         rd_cnt = 0, done_cnt = 0;
    int         fall_cyc = 0, done_cyc = -1, frame_len = 0, empty_fall_cyc = 0;
    int         gap_from = 1 << 30, gap_min = 999, gap_max = -1;
    logic       prev_tx = 1'b1, prev_empty = 1'b1;
    int         rx_t = -1;
    logic [9:0] rx_bits = '0, last_bits = '0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin : cmp_blk
        logic e_tx;
        int   k;
        if (started) begin
            k = 0;
            if (m_t < 3) e_tx = 1'b1;
            else begin
                k = (m_t - 3) / C;
                e_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[k-1];
            end
            chk("tx", tx, e_tx);
            chk("fifo_rd", fifo_rd, m_t == 1);
            chk("busy", busy, m_t >= 1);
            chk("tx_done", tx_done, m_t == FRAME + 2);

            rd_cnt   += fifo_rd;
            done_cnt += tx_done;
            if (prev_empty && !dut_empty) empty_fall_cyc = cyc;

            // Line receiver: samples each bit mid-period.
            if (rst_edge) rx_t = -1;
            else begin
                if (rx_t < 0 && prev_tx && !tx) begin
                    rx_t = 0;
                    if (done_cyc > gap_from) begin
                        if (cyc - done_cyc - 1 < gap_min) gap_min = cyc - done_cyc - 1;
                        if (cyc - done_cyc - 1 > gap_max) gap_max = cyc - done_cyc - 1;
                    end
                    fall_cyc = cyc;
                end
                if (rx_t >= 0) begin
                    if (rx_t % C == C / 2) rx_bits[rx_t / C] = tx;
                    rx_t++;
                    if (rx_t == FRAME) begin
                        rx_q.push_back(rx_bits[8:1]);
                        last_bits = rx_bits;
                        $display("frame %0d byte=0x%02h bits=%b cycle=%0d",
                                 rx_q.size(), rx_bits[8:1], rx_bits, cyc);
                        rx_t = -1;
                    end
                end
            end
            if (tx_done) begin
                done_cyc  = cyc;
                frame_len = cyc - fall_cyc + 1;
            end
            prev_tx    = tx;
            prev_empty = dut_empty;

            noise_on    = test6 && (m_t >= 3);
            noise_empty = 1'($urandom_range(0, 1));
            noise_data  = 8'($urandom);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr = 1'b1;
        wdata = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, done_cnt, target);
    endtask

    initial begin
        int base_rx, base_rd, base_done;
        logic [7:0] sent[$];

        // Reset with the FIFO already holding a byte.
        rst = 1'b1; en = 1'b1;
        push_byte(8'h3C);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_fifo_rd", fifo_rd, 0);
        end
        chk("rst_fifo_nonempty", dut_empty, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("first_rd_after_release", fifo_rd, 1);
        wait_done(1, FRAME + 20, "t1_timeout");
        chk("t1_byte", rx_q[0], 8'h3C);

        // Single byte 0xA5 from an empty FIFO.
        repeat (5) @(negedge clk);
        base_rd = rd_cnt; base_done = done_cnt;
        push_byte(8'hA5);
        wait_done(base_done + 1, FRAME + 20, "t2_timeout");
        chk("t2_latency", fall_cyc - empty_fall_cyc, 3);
        chk("t2_bits", last_bits, 10'h34A);
        chk("t2_frame_len", frame_len, 40);
        repeat (10) @(negedge clk);
        #1;
        chk("t2_done_pulses", done_cnt - base_done, 1);
        chk("t2_rd_pulses", rd_cnt - base_rd, 1);

        // Fill the FIFO to full, then drain back-to-back.
        en = 1'b0;
        base_rx = rx_q.size(); base_rd = rd_cnt; base_done = done_cnt;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        @(negedge clk); #1;
        chk("t3_fifo_full", fq.size(), 8);
        gap_from = cyc; gap_min = 999; gap_max = -1;
        en = 1'b1;
        wait_done(base_done + 8, 8 * (FRAME + 3) + 50, "t3_timeout");
        for (int i = 0; i < 8; i++) chk("t3_order", rx_q[base_rx + i], i + 1);
        chk("t3_rd_pulses", rd_cnt - base_rd, 8);
        chk("t3_gap_min", gap_min, 3);
        chk("t3_gap_max", gap_max, 3);
        repeat (3) @(negedge clk);
        #1;
        chk("t3_fifo_cnt", fq.size(), 0);
        chk("t3_busy", busy, 0);
        gap_from = 1 << 30;

        // en dropped mid-frame with two bytes queued.
        en = 1'b0;
        base_rx = rx_q.size(); base_rd = rd_cnt; base_done = done_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        @(negedge clk);
        en = 1'b1;
        repeat (3 + 3 * C) @(negedge clk);
        en = 1'b0;
        wait_done(base_done + 1, FRAME + 20, "t4_timeout");
        repeat (20) @(negedge clk);
        #1;
        chk("t4_rd_pulses", rd_cnt - base_rd, 1);
        chk("t4_fifo_cnt", fq.size(), 1);
        chk("t4_busy", busy, 0);
        en = 1'b1;
        wait_done(base_done + 2, FRAME + 20, "t4b_timeout");
        chk("t4_byte1", rx_q[base_rx], 8'h11);
        chk("t4_byte2", rx_q[base_rx + 1], 8'h22);

        // Reset pulse during data bit 3.
        en = 1'b0;
        base_rx = rx_q.size(); base_rd = rd_cnt; base_done = done_cnt;
        push_byte(8'h5A);
        push_byte(8'hC3);
        @(negedge clk);
        en = 1'b1;
        repeat (3 + 4 * C + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_tx_after_rst", tx, 1);
        chk("t5_busy_after_rst", busy, 0);
        wait_done(base_done + 1, FRAME + 20, "t5_timeout");
        chk("t5_frames", rx_q.size() - base_rx, 1);
        chk("t5_byte", rx_q[rx_q.size() - 1], 8'hC3);
        chk("t5_rd_pulses", rd_cnt - base_rd, 2);

        // FIFO flags and data churn while the frame is on the line.
        repeat (5) @(negedge clk);
        base_rx = rx_q.size(); base_rd = rd_cnt; base_done = done_cnt;
        test6 = 1'b1;
        push_byte(8'h96);
        wait_done(base_done + 1, FRAME + 20, "t6_timeout");
        test6 = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_byte", rx_q[base_rx], 8'h96);
        chk("t6_rd_pulses", rd_cnt - base_rd, 1);
        chk("t6_done_pulses", done_cnt - base_done, 1);

        // Random writes and en toggling, then drain.
        base_rx = rx_q.size(); base_done = done_cnt;
        repeat (800) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            if (fq.size() < 7 && $urandom_range(0, 5) == 0) begin
                wr = 1'b1;
                wdata = 8'($urandom);
                sent.push_back(wdata);
            end else wr = 1'b0;
        end
        @(negedge clk);
        wr = 1'b0;
        en = 1'b1;
        wait_done(base_done + sent.size(), 10 * (FRAME + 3) + 100, "t7_timeout");
        chk("t7_frames", rx_q.size() - base_rx, sent.size());
        for (int i = 0; i < sent.size() && base_rx + i < rx_q.size(); i++)
            chk("t7_byte", rx_q[base_rx + i], sent[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
